// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared record layout, default watch mask and register indices
package trace_pkg;

  localparam logic [31:0] DEFAULT_WATCH_MASK = 32'h03FF_FF00;

  localparam int REG_ZERO = 0;
  localparam int REG_AT   = 1;
  localparam int REG_T0   = 8;
  localparam int REG_T7   = 15;
  localparam int REG_S0   = 16;
  localparam int REG_S7   = 23;
  localparam int REG_T8   = 24;
  localparam int REG_T9   = 25;
  localparam int REG_K0   = 26;
  localparam int REG_RA   = 31;

  // Record is packed MSB to LSB as {cycle, pc, addr, data}.
  function automatic int rec_width(int cyc_w, int pc_w, int addr_w, int data_w);
    return cyc_w + pc_w + addr_w + data_w;
  endfunction

  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int addr_lsb(int data_w);
    return data_w;
  endfunction

  function automatic int pc_lsb(int data_w, int addr_w);
    return data_w + addr_w;
  endfunction

  function automatic int cyc_lsb(int data_w, int addr_w, int pc_w);
    return data_w + addr_w + pc_w;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO with count-based full/empty
// The head is held in a register so it stays put once the FIFO drains.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (count_d != '0) head_d = mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign dout  = head_q;
  assign count = count_q;

endmodule

// File: rtl/regwrite_trace_monitor.sv
// rtl/regwrite_trace_monitor.sv - captures watched WB register writes as timestamped records
// Never stalls the pipeline: when the buffer is full the record is dropped and counted.
module regwrite_trace_monitor
  import trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int ADDR_W = 5,
  parameter int CYC_W  = 16,
  parameter int DEPTH  = 8,
  parameter logic [(2**ADDR_W)-1:0] WATCH_MASK = DEFAULT_WATCH_MASK,
  parameter int DROP_W = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 trace_en,
  input  logic                                 clear,
  input  logic                                 wb_we,
  input  logic [ADDR_W-1:0]                    wb_addr,
  input  logic [DATA_W-1:0]                    wb_data,
  input  logic [PC_W-1:0]                      wb_pc,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [CYC_W+PC_W+ADDR_W+DATA_W-1:0]  out_rec,
  output logic [$clog2(DEPTH):0]               fifo_count,
  output logic                                 overflow,
  output logic [DROP_W-1:0]                    drop_cnt
);

  localparam int REC_W = rec_width(CYC_W, PC_W, ADDR_W, DATA_W);

  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;
  logic              capture, pop_fire, drop, fifo_full, fifo_empty;
  logic [REC_W-1:0]  rec_in;

  assign capture  = trace_en && wb_we && (wb_addr != '0) && WATCH_MASK[wb_addr];
  assign pop_fire = !fifo_empty && out_ready;
  assign drop     = capture && fifo_full && !pop_fire;
  assign rec_in   = {cyc_q, wb_pc, wb_addr, wb_data};

  sync_fifo_fwft #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (capture),
    .pop   (out_ready),
    .din   (rec_in),
    .dout  (out_rec),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Clear wins over a drop on the same edge, so a discarded capture is not counted.
  always_comb begin
    cyc_d      = cyc_q + CYC_W'(1);
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (clear) begin
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      cyc_q      <= cyc_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
